vga_hex_counter_block: RTL and testbench
========================================

// Module: vga_hex_counter_block
// PURPOSE
//  Parametrised on-screen hex counter layer for the VGA text pipeline. It owns a WIDTH-bit
//  frame-paced counter and renders it as WIDTH/4 hex glyph cells at a configurable grid
//  position, zoom and colour. Outputs drive the OR-combined char/colour/zoom bus feeding the font stage.
//  Drops into the stage-1 slot of a label block: x/y in, char/colour/zoom out one clock later.
// PARAMETERS
//  WIDTH            8        counter width; multiple of 4, range 4..32; DIGITS = WIDTH/4
//  LINE             8        glyph-grid row of the display (units of 8<<PZOOM px)
//  COL              9        glyph-grid column of the most significant digit
//  PZOOM            2        zoom exponent 0..3; glyph cell = (8<<PZOOM) px square
//  PCOLOR           `GREEN   3-bit rgb colour of the digits
//  FRAMES_PER_STEP  8        frames per counter step, 1..255
//  DOWN             0        0 = count up, 1 = count down
//  H_LAST / V_LAST  639/479  last active pixel column/row; both together define the end of frame
// PORTS
//  px_clk    in   1      pixel clock; only clock
//  rst_n     in   1      asynchronous active-low reset
//  x         in   10     pixel column, stage-1 aligned
//  y         in   10     pixel row, stage-1 aligned
//  en        in   1      1 = counter advances on paced frames; 0 = hold
//  load      in   1      synchronous load strobe
//  load_val  in   WIDTH  value loaded when load=1
//  char_code out  8      ASCII of digit under (x,y); 8'h00 when not hit
//  color     out  3      PCOLOR when hit, else 3'b000
//  zoom      out  2      PZOOM when hit, else 2'b00
//  hit       out  1      (x,y) lies inside the digit field
//  value     out  WIDTH  live counter value
//  wrap      out  1      one-cycle pulse when a step wraps modulo 2^WIDTH
// BEHAVIOUR
//  - Reset (async assert, sync release): value=0, disp=0, prescaler=0, frame_tick=0.
//    All outputs are 0. Reset mid-frame blanks the field from the next clock onward.
//  - frame_tick: registered, equals (x==H_LAST && y==V_LAST); high exactly one cycle per frame.
//  - Prescaler: on frame_tick, if en, increments; on reaching FRAMES_PER_STEP-1 it returns to 0 and a step fires.
//    The prescaler holds while en=0.
//  - Step: value +/- 1 modulo 2^WIDTH (per DOWN). wrap=1 the same cycle value changes if it crossed
//    all-ones->0 (up) or 0->all-ones (down).
//  - load has priority: if load and step coincide, value<=load_val, prescaler<=0, wrap=0.
//  - Tear-free display: disp (render copy) updates only on frame_tick, taking value's post-update
//    value for that cycle. A load mid-frame appears on screen at the next frame_tick, never mid-frame.
//  - Render: cx=x>>(3+PZOOM), cy=y>>(3+PZOOM). The pixel is a hit when cy==LINE and COL<=cx<COL+DIGITS.
//    i=cx-COL; nibble=disp[(DIGITS-1-i)*4 +: 4]; char = '0'..'9' for 0-9, 'A'..'F' for A-F.
//  - Latency: char_code/color/zoom/hit registered, exactly 1 px_clk after x/y. When not a hit,
//    outputs are all-zero so they may be OR'd with other blocks.
//  - Width arithmetic: cx/cy are 10-bit unsigned; COL+DIGITS is compared in 11 bits (no overflow).
// CONFIGURATION
//  VGA_HEX_BLINK_EN defined:
//    - An internal 5-bit frame count increments on every frame_tick.
//    - While en==0, color is forced to 3'b000 whenever frame count bit 4 is 1, so the paused
//      counter blinks with a 32-frame period. char_code, zoom and hit are unaffected.
//    - Blink count resets to 0.
//  VGA_HEX_BLINK_EN undefined: no blink count; color = PCOLOR on every hit regardless of en.
// STRUCTURE
//  - const.vh (shared): colour macros, FONT_WIDTH, H_LAST/V_LAST defaults.
//  - Sub-modules: nibble-to-ASCII conversion reuses nibble2digit. One new sub-module,
//    vga_frame_pacer, holds frame_tick detection, the prescaler and the optional blink count,
//    and outputs step and frame_tick.
// TESTING
//  1 Reset mid-frame with value=0x37 -> next clock all outputs 0; after release value=0x00.
//  2 en=1, defaults, 8 frames -> value 0x00->0x01 on the 8th frame_tick; disp=0x01 in the same cycle; wrap=0.
//  3 load_val=0xFF, load, 8 frames -> value=0x00 and wrap=1 for exactly one cycle.
//    With DOWN=1 from 0x00 -> value=0xFF and wrap=1.
//  4 load=1 in the same cycle as a step, load_val=0x42 -> value=0x42, wrap=0, prescaler=0.
//  5 disp=0xA5:
//    - x=288,y=256 -> after 1 clk char=8'h41, color=`GREEN, zoom=2, hit=1.
//    - x=320 -> char=8'h35.
//    - x=352 or y=224 -> all outputs 0.
//    - mid-frame load 0x10 -> char unchanged until frame_tick.
//  6 VGA_HEX_BLINK_EN defined, en=0, 64 frames -> color=`GREEN for frames with count[4]=0
//    and 0 otherwise, with char unchanged; undefined -> color=`GREEN on every frame.

Source files
------------

// File: rtl/vga_hex_counter_block_pkg.sv
// Shared constants and helpers for the on-screen hex counter layer.
// Holds the colour codes, the default end-of-frame coordinates and the
// nibble-to-ASCII conversion used when rendering digits.
package vga_hex_counter_block_pkg;

    // 3-bit rgb colour codes ({r,g,b})
    localparam logic [2:0] COLOR_GREEN = 3'b010;

    // Last active pixel column/row of a 640x480 frame
    localparam int H_LAST_DEF = 639;
    localparam int V_LAST_DEF = 479;

    // Hex nibble to ASCII glyph code: '0'..'9' then 'A'..'F'
    function automatic logic [7:0] nibble2digit(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/vga_frame_pacer.sv
// Frame pacing for the hex counter: registered end-of-frame detection,
// the frames-per-step prescaler and, when VGA_HEX_BLINK_EN is defined,
// a free-running 5-bit frame count whose MSB drives the pause blink.
module vga_frame_pacer
    import vga_hex_counter_block_pkg::*;
#(
    parameter int H_LAST          = H_LAST_DEF,
    parameter int V_LAST          = V_LAST_DEF,
    parameter int FRAMES_PER_STEP = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic       i_en,
    input  logic       i_load,
    output logic       o_frame_tick,
    output logic       o_step
`ifdef VGA_HEX_BLINK_EN
    ,
    output logic       o_blink
`endif
);

    localparam logic [7:0] PRESC_LAST = 8'(FRAMES_PER_STEP - 1);

    logic       r_frame_tick;
    logic [7:0] r_presc;

    // One-cycle pulse the clock after the last active pixel of the frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= (i_x == 10'(H_LAST)) && (i_y == 10'(V_LAST));
        end
    end

    // Prescaler: counts enabled frames, wraps at FRAMES_PER_STEP-1; a load restarts it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= 8'd0;
        end else if (i_load) begin
            r_presc <= 8'd0;
        end else if (r_frame_tick && i_en) begin
            if (r_presc == PRESC_LAST) begin
                r_presc <= 8'd0;
            end else begin
                r_presc <= r_presc + 8'd1;
            end
        end
    end

    assign o_frame_tick = r_frame_tick;
    assign o_step       = r_frame_tick && i_en && (r_presc == PRESC_LAST);

`ifdef VGA_HEX_BLINK_EN
    logic [4:0] r_blink_cnt;

    // Free-running frame count; bit 4 gives a 32-frame blink period
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blink_cnt <= 5'd0;
        end else if (r_frame_tick) begin
            r_blink_cnt <= r_blink_cnt + 5'd1;
        end
    end

    assign o_blink = r_blink_cnt[4];
`endif

endmodule

// File: rtl/vga_hex_counter_block.sv
// On-screen hex counter layer for the VGA text pipeline.
// Owns a WIDTH-bit frame-paced counter and renders it as WIDTH/4 hex glyphs
// at grid (LINE, COL) with zoom PZOOM and colour PCOLOR. Outputs are one
// clock behind x/y and all-zero off the digit field so they can be OR'd.
// Optional build macro: VGA_HEX_BLINK_EN (blink the colour while paused).
module vga_hex_counter_block
    import vga_hex_counter_block_pkg::*;
#(
    parameter int         WIDTH           = 8,
    parameter int         LINE            = 8,
    parameter int         COL             = 9,
    parameter int         PZOOM           = 2,
    parameter logic [2:0] PCOLOR          = COLOR_GREEN,
    parameter int         FRAMES_PER_STEP = 8,
    parameter bit         DOWN            = 1'b0,
    parameter int         H_LAST          = H_LAST_DEF,
    parameter int         V_LAST          = V_LAST_DEF
) (
    input  logic             px_clk,
    input  logic             rst_n,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [7:0]       char_code,
    output logic [2:0]       color,
    output logic [1:0]       zoom,
    output logic             hit,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    localparam int DIGITS = WIDTH / 4;

    logic             w_frame_tick;
    logic             w_step;
    logic [WIDTH-1:0] w_value_next;
    logic             w_wrap_next;
    logic [9:0]       w_cx;
    logic [9:0]       w_cy;
    logic [9:0]       w_idx;
    logic             w_hit;
    logic [3:0]       w_nibble;
    logic [2:0]       w_color;

    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] r_disp;
    logic             r_wrap;
    logic [7:0]       r_char;
    logic [2:0]       r_color;
    logic [1:0]       r_zoom;
    logic             r_hit;

`ifdef VGA_HEX_BLINK_EN
    logic             w_blink;
`endif

    vga_frame_pacer #(
        .H_LAST          (H_LAST),
        .V_LAST          (V_LAST),
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_pacer (
        .i_clk        (px_clk),
        .i_rst_n      (rst_n),
        .i_x          (x),
        .i_y          (y),
        .i_en         (en),
        .i_load       (load),
        .o_frame_tick (w_frame_tick),
        .o_step       (w_step)
`ifdef VGA_HEX_BLINK_EN
        ,
        .o_blink      (w_blink)
`endif
    );

    // Next counter value: load beats a step and never reports a wrap
    always_comb begin
        w_value_next = r_value;
        w_wrap_next  = 1'b0;
        if (load) begin
            w_value_next = load_val;
        end else if (w_step) begin
            if (DOWN) begin
                w_value_next = r_value - {{(WIDTH-1){1'b0}}, 1'b1};
                w_wrap_next  = (r_value == '0);
            end else begin
                w_value_next = r_value + {{(WIDTH-1){1'b0}}, 1'b1};
                w_wrap_next  = (r_value == '1);
            end
        end
    end

    // Live counter, wrap pulse, and the render copy refreshed only at frame end
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_wrap  <= 1'b0;
            r_disp  <= '0;
        end else begin
            r_value <= w_value_next;
            r_wrap  <= w_wrap_next;
            if (w_frame_tick) begin
                r_disp <= w_value_next;
            end
        end
    end

    // Map the pixel to a glyph cell and pick the digit nibble under it
    always_comb begin
        w_cx     = x >> (3 + PZOOM);
        w_cy     = y >> (3 + PZOOM);
        w_idx    = w_cx - 10'(COL);
        w_hit    = (w_cy == 10'(LINE)) &&
                   ({1'b0, w_cx} >= 11'(COL)) &&
                   ({1'b0, w_cx} <  11'(COL + DIGITS));
        w_nibble = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_idx == 10'(k)) begin
                w_nibble = r_disp[(DIGITS-1-k)*4 +: 4];
            end
        end
    end

    // Digit colour, optionally blanked on alternate 16-frame halves while paused
    always_comb begin
`ifdef VGA_HEX_BLINK_EN
        w_color = (!en && w_blink) ? 3'b000 : PCOLOR;
`else
        w_color = PCOLOR;
`endif
    end

    // Registered render outputs, zero off the digit field
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_char  <= 8'h00;
            r_color <= 3'b000;
            r_zoom  <= 2'b00;
            r_hit   <= 1'b0;
        end else if (w_hit) begin
            r_char  <= nibble2digit(w_nibble);
            r_color <= w_color;
            r_zoom  <= 2'(PZOOM);
            r_hit   <= 1'b1;
        end else begin
            r_char  <= 8'h00;
            r_color <= 3'b000;
            r_zoom  <= 2'b00;
            r_hit   <= 1'b0;
        end
    end

    assign char_code = r_char;
    assign color     = r_color;
    assign zoom      = r_zoom;
    assign hit       = r_hit;
    assign value     = r_value;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_vga_hex_counter_block.sv
// Bench for vga_hex_counter_block: directed steps followed by random
// traffic, checked against a frame-level model of the counter and screen.
// Instance a uses the defaults; instance b counts down one step per frame.
module tb_vga_hex_counter_block;

    logic       px_clk = 1'b0;
    logic       rst_n;
    logic [9:0] x, y;
    logic       en, load;
    logic [7:0] load_val;

    logic [7:0] char_a, char_b, value_a, value_b;
    logic [2:0] color_a, color_b;
    logic [1:0] zoom_a, zoom_b;
    logic       hit_a, hit_b, wrap_a, wrap_b;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_val_a, m_cnt_a, m_disp_a, m_val_b, m_disp_b, m_frames;
    bit m_wrap_a, m_wrap_b;

    vga_hex_counter_block u_dut_a (
        .px_clk(px_clk), .rst_n(rst_n), .x(x), .y(y), .en(en), .load(load),
        .load_val(load_val), .char_code(char_a), .color(color_a), .zoom(zoom_a),
        .hit(hit_a), .value(value_a), .wrap(wrap_a)
    );

    vga_hex_counter_block #(.DOWN(1'b1), .FRAMES_PER_STEP(1)) u_dut_b (
        .px_clk(px_clk), .rst_n(rst_n), .x(x), .y(y), .en(en), .load(load),
        .load_val(load_val), .char_code(char_b), .color(color_b), .zoom(zoom_b),
        .hit(hit_b), .value(value_b), .wrap(wrap_b)
    );

    always #5 px_clk = ~px_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge px_clk);
        #1;
    endtask

    task automatic model_reset();
        m_val_a = 0; m_cnt_a = 0; m_disp_a = 0;
        m_val_b = 0; m_disp_b = 0; m_frames = 0;
        m_wrap_a = 0; m_wrap_b = 0;
    endtask

    // plain load between frames
    task automatic do_load(input logic [7:0] lv);
        load = 1'b1; load_val = lv;
        step_clk();
        load = 1'b0;
        m_val_a = lv; m_cnt_a = 0; m_val_b = lv;
        chk("load_value_a", value_a, 32'(m_val_a));
        chk("load_value_b", value_b, 32'(m_val_b));
        chk("load_wrap_a", wrap_a, 32'd0);
    endtask

    // one end-of-frame event; ld puts a load in the cycle that acts on it
    task automatic do_frame(input bit ld, input logic [7:0] lv);
        x = 10'd639; y = 10'd479;
        step_clk();
        x = 10'd0; y = 10'd0; load = ld; load_val = lv;
        step_clk();
        load = 1'b0;
        m_frames++;
        m_wrap_a = 0; m_wrap_b = 0;
        if (ld) begin
            m_val_a = lv; m_cnt_a = 0; m_val_b = lv;
        end else if (en) begin
            m_cnt_a++;
            if (m_cnt_a == 8) begin
                m_cnt_a = 0;
                m_wrap_a = (m_val_a == 255);
                m_val_a = (m_val_a + 1) % 256;
            end
            m_wrap_b = (m_val_b == 0);
            m_val_b = (m_val_b + 255) % 256;
        end
        m_disp_a = m_val_a;
        m_disp_b = m_val_b;
        chk("frame_value_a", value_a, 32'(m_val_a));
        chk("frame_wrap_a", wrap_a, 32'(m_wrap_a));
        chk("frame_value_b", value_b, 32'(m_val_b));
        chk("frame_wrap_b", wrap_b, 32'(m_wrap_b));
        step_clk();
        chk("wrap_pulse_a", wrap_a, 32'd0);
        chk("wrap_pulse_b", wrap_b, 32'd0);
    endtask

    function automatic int exp_char(input int disp, input int xx, input int yy);
        int cx, cy, nib;
        cx = xx / 32; cy = yy / 32;
        if (cy != 8 || cx < 9 || cx > 10) return 0;
        nib = (disp >> (4 * (10 - cx))) % 16;
        return (nib < 10) ? 48 + nib : 55 + nib;
    endfunction

    task automatic render(input int xx, input int yy);
        int ea, eb, ecol;
        bit blank;
        x = 10'(xx); y = 10'(yy);
        step_clk();
        ea = exp_char(m_disp_a, xx, yy);
        eb = exp_char(m_disp_b, xx, yy);
        blank = 1'b0;
`ifdef VGA_HEX_BLINK_EN
        blank = !en && (((m_frames / 16) % 2) == 1);
`endif
        ecol = (ea != 0 && !blank) ? 2 : 0;
        chk("char_a", char_a, 32'(ea));
        chk("hit_a", hit_a, 32'(ea != 0));
        chk("zoom_a", zoom_a, (ea != 0) ? 32'd2 : 32'd0);
        chk("color_a", color_a, 32'(ecol));
        chk("char_b", char_b, 32'(eb));
        chk("color_b", color_b, 32'(ecol));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val = 8'h00;
        x = 10'd0; y = 10'd0;
        model_reset();
        repeat (3) step_clk();
        rst_n = 1'b1;
        step_clk();
        chk("rst_value", value_a, 32'd0);
        chk("rst_wrap", wrap_a, 32'd0);
        chk("rst_hit", hit_a, 32'd0);
        chk("rst_char", char_a, 32'd0);

        // mid-frame reset with 0x37 on screen
        do_load(8'h37);
        do_frame(1'b0, 8'h00);
        render(288, 256);
        chk("t1_char_pre", char_a, 32'h33);
        @(negedge px_clk);
        rst_n = 1'b0;
        #1;
        chk("t1_async_char", char_a, 32'd0);
        chk("t1_async_hit", hit_a, 32'd0);
        chk("t1_async_color", color_a, 32'd0);
        chk("t1_async_value", value_a, 32'd0);
        step_clk();
        chk("t1_held_hit", hit_a, 32'd0);
        rst_n = 1'b1;
        model_reset();
        step_clk();
        chk("t1_release_value", value_a, 32'd0);
        render(288, 256);

        // 8 enabled frames give one up-step; instance b wraps 0 -> FF on the first
        en = 1'b1;
        for (int i = 0; i < 8; i++) do_frame(1'b0, 8'h00);
        chk("t2_value", value_a, 32'h01);
        render(320, 256);
        render(288, 256);

        // FF -> 00 wrap
        do_load(8'hFF);
        for (int i = 0; i < 8; i++) do_frame(1'b0, 8'h00);
        chk("t3_value", value_a, 32'h00);

        // load coincident with a step
        do_load(8'h00);
        for (int i = 0; i < 7; i++) do_frame(1'b0, 8'h00);
        do_frame(1'b1, 8'h42);
        chk("t4_value", value_a, 32'h42);
        for (int i = 0; i < 8; i++) do_frame(1'b0, 8'h00);
        chk("t4_presc_restart", value_a, 32'h43);

        // rendering of A5 and field boundaries
        do_load(8'hA5);
        en = 1'b0;
        do_frame(1'b0, 8'h00);
        render(288, 256);
        render(320, 256);
        render(352, 256);
        render(288, 224);
        render(287, 256);
        render(351, 287);
        render(300, 288);
        do_load(8'h10);
        render(288, 256);
        chk("t5_tear_free", char_a, 32'h41);
        do_frame(1'b0, 8'h00);
        render(288, 256);

        // paused blink over 64 frames
        for (int i = 0; i < 64; i++) begin
            do_frame(1'b0, 8'h00);
            render(320, 260);
        end

        // random traffic
        for (int i = 0; i < 150; i++) begin
            int r, rx, ry;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                en = 1'($urandom_range(0, 1));
            end else if (r == 1) begin
                do_load(8'($urandom_range(0, 255)));
            end else if (r <= 5) begin
                do_frame($urandom_range(0, 5) == 0, 8'($urandom_range(0, 255)));
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    rx = $urandom_range(256, 383);
                    ry = $urandom_range(224, 300);
                end else begin
                    rx = $urandom_range(0, 638);
                    ry = $urandom_range(0, 479);
                end
                render(rx, ry);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
